traffic_phase_scheduler: RTL

Demand-actuated sequencer for the two-way intersection lamps at 16 MHz.
- Latches vehicle/pedestrian demand for approach 1 and approach 2.
- Grants green to one approach at a time, enforcing minimum green, maximum green, yellow and all-red clearance.
- Drives the six lamp outputs directly.
- Replaces fixed-time cycling: an approach with no opposing demand rests in green indefinitely.

---
 rtl/traffic_phase_scheduler.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/traffic_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : traffic_phase_scheduler
// Brief   : Demand-actuated two-approach lamp sequencer with min/max green,
//           yellow and all-red clearance. NIGHT_FLASH_EN adds a flash input.
// Rev     : 1.0  initial release
// ============================================================================
module traffic_phase_scheduler #(
    parameter int unsigned TICK_CYCLES = 32'd16_000_000,
    parameter logic [7:0]  MIN_GREEN   = 8'd10,
    parameter logic [7:0]  MAX_GREEN   = 8'd30,
    parameter logic [7:0]  YELLOW_T    = 8'd5,
    parameter logic [7:0]  ALLRED_T    = 8'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req1,
    input  logic       req2,
`ifdef NIGHT_FLASH_EN
    input  logic       flash,
`endif
    output logic       red1,
    output logic       yellow1,
    output logic       green1,
    output logic       red2,
    output logic       yellow2,
    output logic       green2,
    output logic [2:0] phase
);

    localparam logic [2:0] c_ST_ALLRED  = 3'd0;
    localparam logic [2:0] c_ST_GREEN1  = 3'd1;
    localparam logic [2:0] c_ST_YELLOW1 = 3'd2;
    localparam logic [2:0] c_ST_GREEN2  = 3'd3;
    localparam logic [2:0] c_ST_YELLOW2 = 3'd4;
`ifdef NIGHT_FLASH_EN
    localparam logic [2:0] c_ST_FLASH   = 3'd5;
`endif
    localparam logic [31:0] c_TICK_LAST = TICK_CYCLES - 32'd1;

    logic [31:0] r_cyc;
    logic [7:0]  r_sec;
    logic [2:0]  r_state;
    logic        r_dir2;
    logic        r_pend1;
    logic        r_pend2;
`ifdef NIGHT_FLASH_EN
    logic        r_flash_yel;
`endif

    logic        w_tick;
    logic [7:0]  w_sec;
    logic [2:0]  w_state_nxt;
    logic        w_dir2_nxt;
    logic        w_trans;
    logic        w_enter_g1;
    logic        w_enter_g2;

    assign w_tick = (r_cyc == c_TICK_LAST);
    // Seconds value including the tick landing this cycle, so a state of N
    // seconds leaves on exactly the edge that completes its Nth tick.
    assign w_sec  = (w_tick && (r_sec != 8'hFF)) ? r_sec + 8'd1 : r_sec;

    always_comb begin
        w_state_nxt = r_state;
        w_dir2_nxt  = r_dir2;
        case (r_state)
            c_ST_ALLRED: begin
                if (w_sec >= ALLRED_T) w_state_nxt = r_dir2 ? c_ST_GREEN2 : c_ST_GREEN1;
`ifdef NIGHT_FLASH_EN
                if ((w_sec >= ALLRED_T) && flash) w_state_nxt = c_ST_FLASH;
`endif
            end
            c_ST_GREEN1: begin
                if (r_pend2 && ((w_sec >= MAX_GREEN) || ((w_sec >= MIN_GREEN) && !req1)))
                    w_state_nxt = c_ST_YELLOW1;
            end
            c_ST_YELLOW1: begin
                if (w_sec >= YELLOW_T) begin
                    w_state_nxt = c_ST_ALLRED;
                    w_dir2_nxt  = 1'b1;
                end
            end
            c_ST_GREEN2: begin
                if (r_pend1 && ((w_sec >= MAX_GREEN) || ((w_sec >= MIN_GREEN) && !req2)))
                    w_state_nxt = c_ST_YELLOW2;
            end
            c_ST_YELLOW2: begin
                if (w_sec >= YELLOW_T) begin
                    w_state_nxt = c_ST_ALLRED;
                    w_dir2_nxt  = 1'b0;
                end
            end
`ifdef NIGHT_FLASH_EN
            c_ST_FLASH: begin
                if (!flash) begin
                    w_state_nxt = c_ST_ALLRED;
                    w_dir2_nxt  = 1'b0;
                end
            end
`endif
            default: begin
                w_state_nxt = c_ST_ALLRED;
                w_dir2_nxt  = 1'b0;
            end
        endcase
    end

    assign w_trans    = (w_state_nxt != r_state);
    assign w_enter_g1 = w_trans && (w_state_nxt == c_ST_GREEN1);
    assign w_enter_g2 = w_trans && (w_state_nxt == c_ST_GREEN2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_ALLRED;
            r_dir2  <= 1'b0;
            r_cyc   <= 32'd0;
            r_sec   <= 8'd0;
            r_pend1 <= 1'b0;
            r_pend2 <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dir2  <= w_dir2_nxt;
            if (w_trans) begin
                r_cyc <= 32'd0;
                r_sec <= 8'd0;
            end else begin
                r_cyc <= w_tick ? 32'd0 : r_cyc + 32'd1;
                r_sec <= w_sec;
            end
            // Clear on green entry dominates a coincident request.
            r_pend1 <= (r_pend1 || (req1 && (r_state != c_ST_GREEN1))) && !w_enter_g1;
            r_pend2 <= (r_pend2 || (req2 && (r_state != c_ST_GREEN2))) && !w_enter_g2;
        end
    end

`ifdef NIGHT_FLASH_EN
    always_ff @(posedge clk) begin
        if (rst || (r_state != c_ST_FLASH)) r_flash_yel <= 1'b1;
        else if (w_tick)                     r_flash_yel <= ~r_flash_yel;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            red1    <= 1'b1;
            yellow1 <= 1'b0;
            green1  <= 1'b0;
            red2    <= 1'b1;
            yellow2 <= 1'b0;
            green2  <= 1'b0;
            phase   <= c_ST_ALLRED;
        end else begin
            red1    <= 1'b0;
            yellow1 <= 1'b0;
            green1  <= 1'b0;
            red2    <= 1'b0;
            yellow2 <= 1'b0;
            green2  <= 1'b0;
            phase   <= r_state;
            case (r_state)
                c_ST_GREEN1:  begin green1  <= 1'b1; red2    <= 1'b1; end
                c_ST_YELLOW1: begin yellow1 <= 1'b1; red2    <= 1'b1; end
                c_ST_GREEN2:  begin red1    <= 1'b1; green2  <= 1'b1; end
                c_ST_YELLOW2: begin red1    <= 1'b1; yellow2 <= 1'b1; end
`ifdef NIGHT_FLASH_EN
                c_ST_FLASH:   begin yellow1 <= r_flash_yel; yellow2 <= r_flash_yel; end
`endif
                default: begin
                    red1  <= 1'b1;
                    red2  <= 1'b1;
                    phase <= c_ST_ALLRED;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
